// File: rtl/video_mnist_color_pkg.sv
// Shared definitions for the MNIST colour-overlay stage: output modes, digit count, colour LUT.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package video_mnist_color_pkg;

    // Output rendering mode; the encoding matches the 2-bit param_mode port.
    typedef enum logic [1:0] {
        MODE_GREY    = 2'd0,
        MODE_OVERLAY = 2'd1,
        MODE_BLEND   = 2'd2,
        MODE_COLOR   = 2'd3
    } mode_e;

    // Classes 0..NUM_DIGIT-1 are digits; anything above is background.
    localparam int NUM_DIGIT = 10;

    // One RGB pixel, R in the top byte as on the output bus.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Resistor colour code; non-digit classes return black.
    function automatic logic [23:0] mnist_digit_color(input logic [31:0] num);
        case (num)
            32'd0:   return 24'h000000;
            32'd1:   return 24'h804000;
            32'd2:   return 24'hFF0000;
            32'd3:   return 24'hFF8000;
            32'd4:   return 24'hFFFF00;
            32'd5:   return 24'h00FF00;
            32'd6:   return 24'h0000FF;
            32'd7:   return 24'h8000FF;
            32'd8:   return 24'h808080;
            32'd9:   return 24'hFFFFFF;
            default: return 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/video_mnist_color_if.sv
// AXI4-Stream bundles for the colour stage: classified grey input and RGB output.
// Latency: n/a (wiring only).
// Backpressure: plain tvalid/tready per stream.
interface video_mnist_color_in_if #(
    parameter int TUSER_WIDTH   = 1,
    parameter int TNUMBER_WIDTH = 4,
    parameter int TCOUNT_WIDTH  = 4
);
    logic [TUSER_WIDTH-1:0]   tuser;
    logic                     tlast;
    logic [TNUMBER_WIDTH-1:0] tnumber;
    logic [TCOUNT_WIDTH-1:0]  tcount;
    logic [7:0]               tdata;
    logic                     tvalid;
    logic                     tready;

    modport master (output tuser, tlast, tnumber, tcount, tdata, tvalid, input tready);
    modport slave  (input tuser, tlast, tnumber, tcount, tdata, tvalid, output tready);
endinterface

interface video_mnist_color_out_if #(
    parameter int TUSER_WIDTH = 1
);
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic [23:0]            tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (output tuser, tlast, tdata, tvalid, input tready);
    modport slave  (input tuser, tlast, tdata, tvalid, output tready);
endinterface

// File: rtl/video_mnist_color_lut.sv
// Class index to resistor-code RGB lookup, shared with the OSD block.
// Latency: 0 cycles, purely combinational.
// Backpressure: none, no handshake.
module video_mnist_color_lut
    import video_mnist_color_pkg::*;
#(
    parameter int TNUMBER_WIDTH = 4
) (
    input  logic [TNUMBER_WIDTH-1:0] i_num,
    output logic                     o_is_digit,
    output logic [23:0]              o_color
);

    logic [31:0] w_num;

    assign w_num      = 32'(i_num);
    assign o_is_digit = (w_num < 32'(NUM_DIGIT));
    assign o_color    = mnist_digit_color(w_num);

endmodule

// File: rtl/video_mnist_color.sv
// Paints recognised MNIST digits over the grey video in resistor-code colours, 1 pixel/cycle.
// Latency: 2 enabled cycles (classify/LUT register, then colour-mix output register).
// Backpressure: whole pipe advances on !m_tvalid || m_tready; s_tready is that enable.
module video_mnist_color
    import video_mnist_color_pkg::*;
#(
    parameter int                      TUSER_WIDTH     = 1,
    parameter int                      TNUMBER_WIDTH   = 4,
    parameter int                      TCOUNT_WIDTH    = 4,
    parameter logic [1:0]              INIT_PARAM_MODE = 2'd1,
    parameter logic [TCOUNT_WIDTH-1:0] INIT_PARAM_TH   = TCOUNT_WIDTH'(2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              param_mode,
    input  logic [TCOUNT_WIDTH-1:0] param_th,
    video_mnist_color_in_if.slave   s_axi4s,
    video_mnist_color_out_if.master m_axi4s
);

    // Per-channel average of grey and colour: 9-bit sum, keep the top 8 bits.
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        return 8'(({1'b0, a} + {1'b0, b}) >> 1);
    endfunction

    // Frame-locked parameters.
    mode_e                   r_mode_act;
    logic [TCOUNT_WIDTH-1:0] r_th_act;

    // Stage 1: classification result plus carried pixel/sideband.
    logic                    r_st1_vld;
    logic                    r_st1_hit;
    mode_e                   r_st1_mode;
    rgb_t                    r_st1_color;
    logic [7:0]              r_st1_grey;
    logic [TUSER_WIDTH-1:0]  r_st1_user;
    logic                    r_st1_last;

    // Stage 2: output register.
    logic                    r_st2_vld;
    rgb_t                    r_st2_dat;
    logic [TUSER_WIDTH-1:0]  r_st2_user;
    logic                    r_st2_last;

    logic                    w_cke;
    logic                    w_sof_accept;
    mode_e                   w_mode_eff;
    logic [TCOUNT_WIDTH-1:0] w_th_eff;
    logic                    w_is_digit;
    logic [23:0]             w_lut_color;
    logic                    w_hit;
    rgb_t                    w_grey3;
    rgb_t                    w_rgb;

    assign w_cke          = !r_st2_vld || m_axi4s.tready;
    assign s_axi4s.tready = w_cke;

    // The SOF beat itself already uses the freshly sampled parameters.
    assign w_sof_accept = s_axi4s.tvalid && w_cke && s_axi4s.tuser[0];
    assign w_mode_eff   = w_sof_accept ? mode_e'(param_mode) : r_mode_act;
    assign w_th_eff     = w_sof_accept ? param_th : r_th_act;

    video_mnist_color_lut #(
        .TNUMBER_WIDTH (TNUMBER_WIDTH)
    ) u_lut (
        .i_num      (s_axi4s.tnumber),
        .o_is_digit (w_is_digit),
        .o_color    (w_lut_color)
    );

    assign w_hit = w_is_digit && (s_axi4s.tcount >= w_th_eff);

    // Latch mode/threshold only on an accepted start-of-frame beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_act <= mode_e'(INIT_PARAM_MODE);
            r_th_act   <= INIT_PARAM_TH;
        end else if (w_sof_accept) begin
            r_mode_act <= mode_e'(param_mode);
            r_th_act   <= param_th;
        end
    end

    // Stage 1 register: bubbles advance as valid=0, payload only loads with a real beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_st1_vld   <= 1'b0;
            r_st1_hit   <= 1'b0;
            r_st1_mode  <= MODE_GREY;
            r_st1_color <= '0;
            r_st1_grey  <= '0;
            r_st1_user  <= '0;
            r_st1_last  <= 1'b0;
        end else if (w_cke) begin
            r_st1_vld <= s_axi4s.tvalid;
            if (s_axi4s.tvalid) begin
                r_st1_hit   <= w_hit;
                r_st1_mode  <= w_mode_eff;
                r_st1_color <= w_lut_color;
                r_st1_grey  <= s_axi4s.tdata;
                r_st1_user  <= s_axi4s.tuser;
                r_st1_last  <= s_axi4s.tlast;
            end
        end
    end

    assign w_grey3 = {r_st1_grey, r_st1_grey, r_st1_grey};

    // Stage 2 colour mix selected by the mode that travelled with the beat.
    always_comb begin
        w_rgb = w_grey3;
        case (r_st1_mode)
            MODE_GREY:    w_rgb = w_grey3;
            MODE_OVERLAY: w_rgb = r_st1_hit ? r_st1_color : w_grey3;
            MODE_BLEND: begin
                if (r_st1_hit) begin
                    w_rgb.r = avg8(r_st1_grey, r_st1_color.r);
                    w_rgb.g = avg8(r_st1_grey, r_st1_color.g);
                    w_rgb.b = avg8(r_st1_grey, r_st1_color.b);
                end
            end
            MODE_COLOR:   w_rgb = r_st1_hit ? r_st1_color : '0;
            default:      w_rgb = w_grey3;
        endcase
    end

    // Output register: holds while stalled because it only loads on the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_st2_vld  <= 1'b0;
            r_st2_dat  <= '0;
            r_st2_user <= '0;
            r_st2_last <= 1'b0;
        end else if (w_cke) begin
            r_st2_vld <= r_st1_vld;
            if (r_st1_vld) begin
                r_st2_dat  <= w_rgb;
                r_st2_user <= r_st1_user;
                r_st2_last <= r_st1_last;
            end
        end
    end

    assign m_axi4s.tvalid = r_st2_vld;
    assign m_axi4s.tdata  = r_st2_dat;
    assign m_axi4s.tuser  = r_st2_user;
    assign m_axi4s.tlast  = r_st2_last;

endmodule
